mux32_rr_sched: RTL and testbench

//  Round-robin scheduler that shares the 32:1 bit mux among N requesters.

---
 rtl/mux_sched_pkg.sv | 35 +++
 rtl/mux321.sv | 13 +
 rtl/mux32_rr_sched.sv | 157 +++++++++++++++
 tb/tb_mux32_rr_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler.
//   state_t  : scheduler FSM states (IDLE, BUSY)
//   SEL_W    : width of the internal requester index (32 requesters max)
//   pick_t   : result of a round-robin search {found, idx}
//   rr_pick  : first set bit of req scanning ptr, ptr+1, .. wrapping to ptr-1
package mux_sched_pkg;

  localparam int MAX_N = 32;
  localparam int SEL_W = 5;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // The candidate index wraps naturally at 32 because it is SEL_W bits wide;
  // requesters beyond N are zero-padded by the caller and never win.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int k = 0; k < MAX_N; k++) begin
      cand = ptr + k[SEL_W-1:0];
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux321.sv
// 32:1 single-bit multiplexer.
//   in  : 32 data bits
//   sel : 5-bit select
//   out : in[sel]
module mux321 (
  input  logic [31:0] in,
  input  logic [4:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule

// File: rtl/mux32_rr_sched.sv
// Round-robin scheduler sharing a 32:1 bit mux among N requesters. The
// winner's data bit is captured into a registered output and offered
// downstream on a valid/ready handshake; the owner gets a one-cycle ack on
// the transfer cycle.
//   clk, rst  : clock, synchronous active-high reset
//   req, in   : per-requester request level and data bit
//   sel       : index of current/last winner (mux select)
//   out       : registered granted data bit, out_valid qualifies it
//   out_ready : downstream accept
//   ack       : one-hot transfer pulse to the beat's owner
// Optional feature: define MUX_BURST_EN to let a winner keep the grant for
// up to MAX_BURST consecutive beats while it keeps requesting.
module mux32_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int N         = 32,
  parameter int SEL_W     = 5,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     in,
  output logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     ack
);

  localparam int IDX_W = mux_sched_pkg::SEL_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if (N < 2 || N > 32 || SEL_W != $clog2(N) || MAX_BURST < 2 || MAX_BURST > 16) begin : g_bad_param
    $error("mux32_rr_sched: illegal parameter combination");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               out_q, out_d;

  logic [MAX_N-1:0]   req_pad, in_pad, pick_req, ack_pad;
  logic [IDX_W-1:0]   next_ptr, pick_ptr, mux_sel;
  logic               transfer, burst_hold, mux_out;
  pick_t              pick;

  always_comb begin
    req_pad        = '0;
    in_pad         = '0;
    req_pad[N-1:0] = req;
    in_pad[N-1:0]  = in;
  end

  assign transfer = (state_q == BUSY) && out_ready;
  assign next_ptr = (sel_q == LAST) ? '0 : sel_q + 1'b1;

  // While BUSY the search looks ahead from the post-transfer pointer with the
  // current owner masked, so the next beat can load on the transfer edge.
  always_comb begin
    if (state_q == BUSY) begin
      pick_req = req_pad & ~(MAX_N'(1) << sel_q);
      pick_ptr = next_ptr;
    end else begin
      pick_req = req_pad;
      pick_ptr = ptr_q;
    end
    pick = rr_pick(pick_req, pick_ptr);
  end

`ifdef MUX_BURST_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  logic [3:0] burst_cnt_q, burst_cnt_d;

  assign burst_hold = transfer && req_pad[sel_q] && (burst_cnt_q < BURST_LAST);

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (transfer) begin
      burst_cnt_d = burst_hold ? burst_cnt_q + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign burst_hold = 1'b0;
`endif

  // Mux select is the index of the beat about to be captured.
  assign mux_sel = burst_hold ? sel_q : pick.idx;

  mux321 u_mux (
    .in  (in_pad),
    .sel (mux_sel),
    .out (mux_out)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    out_d   = out_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = BUSY;
          sel_d   = pick.idx;
          out_d   = mux_out;
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (burst_hold) begin
            out_d = mux_out;
          end else begin
            ptr_d = next_ptr;
            if (pick.found) begin
              sel_d = pick.idx;
              out_d = mux_out;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      out_q   <= out_d;
    end
  end

  // A beat caught by reset is dropped silently, so ack is masked by rst.
  assign ack_pad   = (transfer && !rst) ? (MAX_N'(1) << sel_q) : '0;
  assign ack       = ack_pad[N-1:0];
  assign out_valid = (state_q == BUSY);
  assign sel       = sel_q[SEL_W-1:0];
  assign out       = out_q;

endmodule

// File: tb/tb_mux32_rr_sched.sv
// Self-checking bench for mux32_rr_sched (N=32). Expected beats {sel, bit}
// are queued as stimulus is applied and compared on each observed transfer.
module tb_mux32_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req;
  logic [31:0] din;
  logic [4:0]  sel;
  logic        dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ack;

  logic [5:0]  sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;

  always #5 clk = ~clk;

  mux32_rr_sched #(.N(32), .SEL_W(5), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in        (din),
    .sel       (sel),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ack       (ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transfer monitor: one line per delivered beat.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 64'(sb.size()), 64'd1);
        end else begin
          logic [5:0] e;
          e = sb.pop_front();
          $display("[TB] beat sel=%0d out=%0d ack=0x%08h", sel, dout, ack);
          check("beat_sel", 64'(sel), 64'(e[5:1]));
          check("beat_out", 64'(dout), 64'(e[0]));
          check("beat_ack", 64'(ack), 64'(32'd1 << e[5:1]));
        end
      end else begin
        check("ack_idle", 64'(ack), 64'd0);
      end
    end
  end

  task automatic push_beat(input int s);
    logic [4:0] s5;
    s5 = s[4:0];
    sb.push_back({s5, din[s5]});
  endtask

  task automatic wait_size(input int target, input int budget, input bit chk_valid);
    int n;
    n = 0;
    while (sb.size() != target && n < budget) begin
      @(negedge clk);
      #1;
      if (chk_valid) check("valid_held", 64'(out_valid), 64'd1);
      n++;
    end
    check("sb_wait", 64'(sb.size()), 64'(target));
  endtask

  task automatic do_reset();
    check("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    @(posedge clk); #1;
    @(negedge clk);
    check(tag, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seq[$];
    rst = 1'b1; req = '0; din = '0; out_ready = 1'b1;

    // 1: reset state held for two cycles and after release with no requests
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_sel", 64'(sel), 64'd0);
      check("rst_out", 64'(dout), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("norq_valid", 64'(out_valid), 64'd0);
    check("norq_sel", 64'(sel), 64'd0);

    // 2: single requester 3
    @(posedge clk); #1;
    req = 32'h0000_0008; din = 32'h0000_0008; out_ready = 1'b1;
    push_beat(3);
    wait_size(0, 10, 1'b0);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    check("single_idle", 64'(out_valid), 64'd0);

    // 3: all requesting, full rotation with no bubbles
    do_reset();
    din = 32'hA5C3_0F96; req = 32'hFFFF_FFFF; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) push_beat(i);
    push_beat(0);
    @(posedge clk); #1;
    wait_size(0, 80, 1'b1);
    req = '0;
    expect_idle("rot_idle");

    // 4: wrap from pointer 31 to 0, then a 5-cycle stall
    do_reset();
    din = 32'h4000_0001; req = 32'h4000_0000; out_ready = 1'b1;
    push_beat(30);
    wait_size(0, 10, 1'b0);
    req = 32'h8000_0001;
    push_beat(31);
    push_beat(0);
    wait_size(1, 10, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    req = 32'h0000_0001;
    repeat (5) begin
      @(negedge clk);
      check("stall_sel", 64'(sel), 64'd0);
      check("stall_out", 64'(dout), 64'(din[0]));
      check("stall_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_size(0, 10, 1'b1);
    req = '0;
    expect_idle("wrap_idle");

    // 5a: requester drops req while its beat is stalled
    do_reset();
    din = 32'h0000_0010; req = 32'h0000_0010; out_ready = 1'b0;
    push_beat(4);
    @(posedge clk); #1;
    req = '0;
    repeat (3) begin
      @(negedge clk);
      check("drop_valid", 64'(out_valid), 64'd1);
      check("drop_sel", 64'(sel), 64'd4);
      check("drop_out", 64'(dout), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_size(0, 10, 1'b0);
    expect_idle("drop_idle");

    // 5b: reset while a beat is stalled
    out_ready = 1'b0; req = 32'h0000_0004; din = 32'h0000_0004;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_sel", 64'(sel), 64'd2);
    @(posedge clk); #1;
    rst = 1'b1; req = '0; out_ready = 1'b1;
    @(negedge clk);
    check("midrst_ack", 64'(ack), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_valid", 64'(out_valid), 64'd0);
    check("postrst_sel", 64'(sel), 64'd0);
    check("postrst_out", 64'(dout), 64'd0);

    // 6: two requesters held, burst vs single-beat grants
    do_reset();
    din = 32'h0000_0020; req = 32'h0000_0021; out_ready = 1'b1;
`ifdef MUX_BURST_EN
    seq = '{0, 0, 0, 0, 5, 5, 5, 5, 0};
`else
    seq = '{0, 5, 0, 5};
`endif
    foreach (seq[i]) push_beat(seq[i]);
    @(posedge clk); #1;
    wait_size(0, 40, 1'b1);
    req = '0;
    expect_idle("pair_idle");

    check("sb_final", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (%0d checks, %0d failed)", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
